// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Function : WIDTH-bit adder split into WIDTH/CHUNK ripple-carry stages with
//            a valid/ready handshake and a global pipeline stall.
// Revision : 1.0
// ============================================================================
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic             st_v [STAGES];
    logic [WIDTH-1:0] st_x [STAGES];
    logic             st_c [STAGES];
    logic             v_in [STAGES];
    logic [WIDTH-1:0] x_in [STAGES];
    logic [WIDTH-1:0] y_in [STAGES];
    logic             c_in [STAGES];

    assign adv      = !st_v[STAGES-1] || out_ready;
    assign in_ready = adv;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic             v_q, v_d;
            logic [WIDTH-1:0] x_q, x_d;
            logic             c_q, c_d;
            logic             carry;
            logic [CHUNK-1:0] ca, cb;

            if (k == 0) begin : g_head
                assign v_in[0] = in_valid;
                assign x_in[0] = a;
                assign y_in[0] = b;
                assign c_in[0] = cy_in;
            end else begin : g_link
                assign v_in[k] = st_v[k-1];
                assign x_in[k] = st_x[k-1];
                assign c_in[k] = st_c[k-1];
            end

            // x carries sum chunks below this stage and raw A chunks above it
            always_comb begin
                v_d   = v_in[k];
                x_d   = x_in[k];
                ca    = x_in[k][k*CHUNK +: CHUNK];
                cb    = y_in[k][k*CHUNK +: CHUNK];
                carry = c_in[k];
                for (int i = 0; i < CHUNK; i++) begin
                    x_d[k*CHUNK+i] = ca[i] ^ cb[i] ^ carry;
                    carry          = (ca[i] & cb[i]) | (carry & (ca[i] ^ cb[i]));
                end
                c_d = carry;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_d;
                    x_q <= x_d;
                    c_q <= c_d;
                end
            end

            assign st_v[k] = v_q;
            assign st_x[k] = x_q;
            assign st_c[k] = c_q;

            if (k < STAGES-1) begin : g_fwd
                logic [WIDTH-1:0] y_q, y_d;
                assign y_d = y_in[k];
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        y_q <= '0;
                    end else if (adv) begin
                        y_q <= y_d;
                    end
                end
                assign y_in[k+1] = y_q;
            end

            if (k == STAGES-1) begin : g_tail
                logic ovf_q, ovf_d;
                // carry into the MSB recovered as a ^ b ^ sum at that bit
                assign ovf_d = x_in[k][WIDTH-1] ^ y_in[k][WIDTH-1] ^ x_d[WIDTH-1] ^ c_d;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        ovf_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q <= ovf_d;
                    end
                end
                assign ovf = ovf_q;
            end
        end
    endgenerate

    assign out_valid = st_v[STAGES-1];
    assign sum       = st_x[STAGES-1];
    assign cy_out    = st_c[STAGES-1];

endmodule
`default_nettype wire
